// File: rtl/tdc_stream_rx.sv
// TDC output stream receiver: reduces each 1-3 beat burst to one record (strongest return,
// beat count, error flags) and queues it in a small FIFO. Optional stats: TDC_RX_STATS_EN.
module tdc_stream_rx #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        TDC_INT,
  input  logic [14:0] TDC_Odata,
  input  logic [4:0]  TDC_Oint,
  input  logic [1:0]  TDC_Onum,
  input  logic        TDC_Olast,
  input  logic        TDC_Ovalid,
  output logic        TDC_Oready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [14:0] res_data,
  output logic [4:0]  res_int,
  output logic [1:0]  res_num,
  output logic [1:0]  res_err,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_errs
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned RW = 24;
  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StRecv, StCommit} state_e;

  state_e      state_q, state_d;
  logic [14:0] best_data_q, best_data_d;
  logic [4:0]  best_int_q, best_int_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  decl_q, decl_d;
  logic        ovf_q, ovf_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  tmo_q, tmo_d;

  logic [RW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          full, hs, push, pop;
  logic [1:0]    cnt_nx, decl_nx;
  logic          ovf_nx;
  logic [RW-1:0] head;

  assign full       = (count_q == CW'(DEPTH));
  assign TDC_Oready = (state_q == StRecv) && !full;
  assign hs         = TDC_Ovalid && TDC_Oready;
  assign push       = (state_q == StCommit);
  assign res_valid  = (count_q != '0);
  assign pop        = res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      best_data_q <= '0;
      best_int_q  <= '0;
      cnt_q       <= '0;
      decl_q      <= '0;
      ovf_q       <= 1'b0;
      err_q       <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      best_data_q <= best_data_d;
      best_int_q  <= best_int_d;
      cnt_q       <= cnt_d;
      decl_q      <= decl_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    best_data_d = best_data_q;
    best_int_d  = best_int_q;
    cnt_d       = cnt_q;
    decl_d      = decl_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    cnt_nx      = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
    decl_nx     = (cnt_q == 2'd0) ? TDC_Onum : decl_q;
    ovf_nx      = ovf_q || (cnt_q == 2'd3);

    unique case (state_q)
      StIdle: begin
        if (TDC_INT) begin
          state_d     = StRecv;
          best_data_d = '0;
          best_int_d  = '0;
          cnt_d       = '0;
          decl_d      = '0;
          ovf_d       = 1'b0;
          err_d       = '0;
          tmo_d       = '0;
        end
      end
      StRecv: begin
        if (hs) begin
          tmo_d  = '0;
          cnt_d  = cnt_nx;
          decl_d = decl_nx;
          ovf_d  = ovf_nx;
          // Beats past the third are accepted but never compete for "best".
          if (cnt_q != 2'd3 && (cnt_q == 2'd0 || TDC_Oint > best_int_q)) begin
            best_data_d = TDC_Odata;
            best_int_d  = TDC_Oint;
          end
          if (TDC_Olast) begin
            state_d = StCommit;
            err_d   = {1'b0, ovf_nx || (cnt_nx != decl_nx)};
          end
        end else if (tmo_q == TmoLast) begin
          if (cnt_q == 2'd0) begin
            state_d = StIdle;
          end else begin
            state_d = StCommit;
            err_d   = {1'b1, ovf_q};
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Result FIFO; pointer wrap relies on DEPTH being a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {best_data_q, best_int_q, cnt_q, err_q};
  end

  // Masking by res_valid gives zeroed outputs after reset without clearing the array.
  assign head = res_valid ? mem_q[rd_ptr_q] : '0;
  assign {res_data, res_int, res_num, res_err} = head;

`ifdef TDC_RX_STATS_EN
  logic [15:0] frames_q, errs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frames_q <= '0;
      errs_q   <= '0;
    end else if (push) begin
      if (frames_q != 16'hFFFF) frames_q <= frames_q + 16'd1;
      if (err_q != 2'b00 && errs_q != 16'hFFFF) errs_q <= errs_q + 16'd1;
    end
  end

  assign stat_frames = frames_q;
  assign stat_errs   = errs_q;
`else
  assign stat_frames = '0;
  assign stat_errs   = '0;
`endif

endmodule

// File: tb/tb_tdc_stream_rx.sv
// Randomised bench for tdc_stream_rx with a burst-level reference model and result scoreboard.
module tb_tdc_stream_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        TDC_INT;
  logic [14:0] TDC_Odata;
  logic [4:0]  TDC_Oint;
  logic [1:0]  TDC_Onum;
  logic        TDC_Olast;
  logic        TDC_Ovalid;
  logic        TDC_Oready;
  logic        res_valid;
  logic        res_ready;
  logic [14:0] res_data;
  logic [4:0]  res_int;
  logic [1:0]  res_num;
  logic [1:0]  res_err;
  logic [15:0] stat_frames;
  logic [15:0] stat_errs;

  always #2 clk = ~clk;

  tdc_stream_rx #(.DEPTH(4), .TIMEOUT(255)) dut (
    .clk        (clk),
    .rst        (rst),
    .TDC_INT    (TDC_INT),
    .TDC_Odata  (TDC_Odata),
    .TDC_Oint   (TDC_Oint),
    .TDC_Onum   (TDC_Onum),
    .TDC_Olast  (TDC_Olast),
    .TDC_Ovalid (TDC_Ovalid),
    .TDC_Oready (TDC_Oready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_int    (res_int),
    .res_num    (res_num),
    .res_err    (res_err),
    .stat_frames(stat_frames),
    .stat_errs  (stat_errs)
  );

  int checks = 0;
  int errors = 0;
  int pop_mode = 1;  // 0 random, 1 hold, 2 always pop
  logic [23:0] exp_q[$];
  int frames_m = 0;
  int errs_m = 0;
  logic [14:0] beat_data[8];
  logic [4:0]  beat_int[8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: choose ready, then compare the head that will pop on the next edge.
  initial begin
    res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (pop_mode == 0)      res_ready = 1'($urandom_range(0, 1));
      else if (pop_mode == 1) res_ready = 1'b0;
      else                    res_ready = 1'b1;
      if (!rst && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_record", 32'(res_valid), 32'd0);
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          check_eq("rec_data", 32'(res_data), 32'(e[23:9]));
          check_eq("rec_int",  32'(res_int),  32'(e[8:4]));
          check_eq("rec_num",  32'(res_num),  32'(e[3:2]));
          check_eq("rec_err",  32'(res_err),  32'(e[1:0]));
        end
      end
    end
  end

  // Record a burst of n beats from beat_* with declared length onum would produce.
  function automatic logic [23:0] model_rec(input int n, input logic [1:0] onum);
    int stored;
    int bi;
    logic err0;
    stored = (n > 3) ? 3 : n;
    bi = 0;
    for (int i = 1; i < stored; i++) if (beat_int[i] > beat_int[bi]) bi = i;
    err0 = (n > 3) || (stored != int'(onum));
    return {beat_data[bi], beat_int[bi], 2'(stored), 1'b0, err0};
  endfunction

  task automatic note_record(input logic [23:0] r);
    exp_q.push_back(r);
    frames_m++;
    if (r[1:0] != 2'b00) errs_m++;
  endtask

  task automatic start_burst();
    tick();
    TDC_INT = 1'b1;
    tick();
    TDC_INT = 1'b0;
  endtask

  task automatic send_beat(input int idx, input logic [1:0] onum, input logic last);
    bit done;
    done = 1'b0;
    TDC_Ovalid = 1'b1;
    TDC_Odata  = beat_data[idx];
    TDC_Oint   = beat_int[idx];
    TDC_Onum   = onum;
    TDC_Olast  = last;
    for (int i = 0; i < 400 && !done; i++) begin
      if (TDC_Oready) done = 1'b1;
      tick();
    end
    if (!done) check_eq("beat_accept", 32'd0, 32'd1);
    TDC_Ovalid = 1'b0;
    TDC_Olast  = 1'b0;
  endtask

  task automatic run_burst(input int n, input logic [1:0] onum, input bit gaps);
    start_burst();
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      send_beat(i, onum, (i == n - 1));
    end
    note_record(model_rec(n, onum));
  endtask

  task automatic drain();
    pop_mode = 2;
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) tick();
    tick();
    check_eq("drained", 32'(exp_q.size()), 32'd0);
    check_eq("empty_after_drain", 32'(res_valid), 32'd0);
    exp_q.delete();
  endtask

  task automatic set_beats(input int n, input bit small_int);
    for (int i = 0; i < n; i++) begin
      beat_data[i] = 15'($urandom_range(0, 32767));
      beat_int[i]  = small_int ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    end
  endtask

  task automatic count_to_idle(input string tag);
    int n;
    n = 0;
    while (TDC_Oready && n < 400) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(n), 32'd255);
  endtask

  task automatic check_stats(input string tag);
`ifdef TDC_RX_STATS_EN
    check_eq({tag, "_frames"}, 32'(stat_frames), 32'(frames_m));
    check_eq({tag, "_errs"},   32'(stat_errs),   32'(errs_m));
`else
    check_eq({tag, "_frames"}, 32'(stat_frames), 32'd0);
    check_eq({tag, "_errs"},   32'(stat_errs),   32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    TDC_INT = 1'b0;
    TDC_Odata = '0;
    TDC_Oint = '0;
    TDC_Onum = '0;
    TDC_Olast = 1'b0;
    TDC_Ovalid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("reset_oready", 32'(TDC_Oready), 32'd0);
    check_eq("reset_valid",  32'(res_valid), 32'd0);
    check_eq("reset_fields", 32'({res_data, res_int, res_num, res_err}), 32'd0);
    check_stats("reset");

    // Strongest of {4,9,9}: tie keeps the earlier beat; latency to res_valid is two cycles.
    pop_mode = 1;
    beat_int[0] = 5'd4;  beat_data[0] = 15'd100;
    beat_int[1] = 5'd9;  beat_data[1] = 15'd200;
    beat_int[2] = 5'd9;  beat_data[2] = 15'd300;
    run_burst(3, 2'd3, 1'b0);
    check_eq("lat_commit_cycle", 32'(res_valid), 32'd0);
    tick();
    check_eq("lat_valid_cycle", 32'(res_valid), 32'd1);
    check_eq("head_data", 32'(res_data), 32'd200);
    check_eq("head_int",  32'(res_int),  32'd9);
    drain();

    // Early last: declared 2, got 1.
    beat_int[0] = 5'd7;  beat_data[0] = 15'd50;
    run_burst(1, 2'd2, 1'b0);
    drain();

    // Five beats, overflow.
    set_beats(5, 1'b0);
    run_burst(5, 2'd3, 1'b1);
    drain();

    // Fill the FIFO, then a fifth burst must stall until one pop.
    pop_mode = 1;
    for (int b = 0; b < 4; b++) begin
      set_beats(1, 1'b0);
      run_burst(1, 2'd1, 1'b0);
    end
    start_burst();
    repeat (3) begin
      check_eq("full_oready_low", 32'(TDC_Oready), 32'd0);
      tick();
    end
    pop_mode = 2;
    tick();
    pop_mode = 1;
    check_eq("oready_after_pop", 32'(TDC_Oready), 32'd1);
    set_beats(1, 1'b0);
    send_beat(0, 2'd1, 1'b1);
    note_record(model_rec(1, 2'd1));
    drain();

    // One beat then silence: timeout commit with err=10.
    set_beats(1, 1'b0);
    start_burst();
    send_beat(0, 2'd1, 1'b0);
    count_to_idle("timeout_cycles_beat");
    note_record({beat_data[0], beat_int[0], 2'd1, 2'b10});
    drain();

    // INT with no beats: silent return to idle.
    start_burst();
    count_to_idle("timeout_cycles_empty");
    repeat (3) tick();
    check_eq("no_record_empty_burst", 32'(res_valid), 32'd0);

    // Reset mid-burst discards the partial burst and clears stats.
    pop_mode = 0;
    set_beats(2, 1'b0);
    start_burst();
    send_beat(0, 2'd3, 1'b0);
    send_beat(1, 2'd3, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    frames_m = 0;
    errs_m = 0;
    check_eq("rst_oready", 32'(TDC_Oready), 32'd0);
    check_eq("rst_valid",  32'(res_valid), 32'd0);
    check_stats("rst");
    repeat (5) tick();
    check_eq("rst_no_record", 32'(res_valid), 32'd0);

    // Three good records plus one error record.
    for (int b = 0; b < 3; b++) begin
      set_beats(2, 1'b1);
      run_burst(2, 2'd2, 1'b0);
    end
    set_beats(2, 1'b1);
    run_burst(2, 2'd0, 1'b0);
    drain();
    check_stats("four_records");

    // Random bursts with random gaps and random downstream back-pressure.
    pop_mode = 0;
    for (int b = 0; b < 40; b++) begin
      int n;
      n = $urandom_range(1, 5);
      set_beats(n, ($urandom_range(0, 1) == 1));
      run_burst(n, 2'($urandom_range(0, 3)), 1'b1);
    end
    drain();
    check_stats("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
